mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single 16-bit main memory port between the I-cache fill FSM, the
//   D-cache fill FSM and the D-cache write-through path. Grants the port for a
//   whole transaction: a fill is held until the owner drops req; a write is a
//   single beat. Each read issue is tagged in a LATENCY-deep pipe, and returned
//   data is routed back to the requester that issued it.
// PARAMETERS
//   LATENCY  4  memory read latency in cycles, from issue to mem_rdata_valid (>=1)
// PORTS
//   clk             in   1   clock, rising edge
//   rst_n           in   1   reset, asynchronous, active-low
//   i_req           in   1   I-cache fill request (fill FSM fsm_busy)
//   i_addr          in   16  I-cache fill word address
//   i_grant         out  1   memory port owned by I-cache fill
//   i_data_valid    out  1   returned word belongs to I-cache
//   i_data          out  16  returned read data for I-cache
//   d_req           in   1   D-cache fill request
//   d_addr          in   16  D-cache fill word address
//   d_grant         out  1   memory port owned by D-cache fill
//   d_data_valid    out  1   returned word belongs to D-cache
//   d_data          out  16  returned read data for D-cache
//   w_req           in   1   write-through store request, held until w_ack
//   w_addr          in   16  store address
//   w_wdata         in   16  store data
//   w_ack           out  1   one-cycle pulse: the store was issued to memory
//   mem_enable      out  1   memory access enable
//   mem_wr          out  1   1 = write, 0 = read
//   mem_addr        out  16  memory address
//   mem_wdata       out  16  memory write data
//   mem_rdata       in   16  memory read data
//   mem_rdata_valid in   1   memory read data valid, LATENCY cycles after the read issue
//   orphan_err      out  1   sticky: mem_rdata_valid arrived with no tag at pipe head
// BEHAVIOUR
//   - Reset (async on rst_n low): state=IDLE, last_fill=I, tag pipe cleared, all outputs 0.
//   - States: IDLE, FILL_I, FILL_D, WRITE. State and grant flops are registered.
//     i_grant = (state==FILL_I); d_grant = (state==FILL_D).
//   - IDLE arbitration, in priority order:
//     w_req -> WRITE; i_req&d_req -> fill not in last_fill; else the sole requester; else stay in IDLE.
//     Entering FILL_x sets last_fill=x.
//   - WRITE (exactly 1 cycle): mem_enable=1, mem_wr=1, mem_addr=w_addr, mem_wdata=w_wdata,
//     w_ack=1; next state is IDLE.
//   - FILL_x: mem_enable=x_req, mem_wr=0, mem_addr=x_addr (combinational pass-through).
//     A cycle with x_req=0 issues nothing and returns to IDLE. Other requests wait.
//   - Every grant change passes through IDLE, so the port is idle for at least 1 cycle between
//     transactions. No preemption: a write that arrives mid-fill waits for the fill to release.
//   - Outside WRITE/FILL, mem_enable=0 and mem_addr/mem_wdata=0.
//   - Tag pipe: each read issue pushes {valid=1,id}; a cycle without a read issue pushes {0,-}.
//     The pipe shifts every cycle. Head = stage LATENCY-1, aligned with mem_rdata_valid.
//     x_data_valid = mem_rdata_valid & head.valid & head.id==x; x_data = mem_rdata.
//     The other requester's data is forced to 0.
//   - Routing uses the tag pipe, not the grant, so words still in flight after a grant change
//     reach the original owner.
//   - mem_rdata_valid with head.valid=0: data is dropped, orphan_err is set and stays set until reset.
//   - Simultaneous w_req, i_req and d_req in IDLE: write first, then fills alternate.
//     A w_req raised while a fill is granted is served at that fill's next IDLE.
//   - Reset mid-transaction: grant is dropped immediately, tags are flushed, and returning data is
//     not routed (no orphan_err for that data, because reset has cleared the flag).
// TESTING
//   1 reset: rst_n=0 async mid-cycle -> all outputs 0, state IDLE; orphan_err=0.
//   2 I fill: i_req=1, addr 0x1230..0x123E -> i_grant 1 cycle later; 8 reads;
//     i_data_valid 4 cycles after each issue, data correct; d_data_valid never 1.
//   3 tie: i_req=d_req=1 from reset -> D granted first (last_fill=I).
//     After D releases: 1 IDLE cycle, then I granted.
//   4 write mid-fill: w_req during FILL_D -> no w_ack until d_req drops.
//     Then IDLE, WRITE: mem_wr=1, addr/data = w_addr/w_wdata, w_ack 1 cycle.
//   5 in-flight routing: D releases with reads outstanding and I is granted next ->
//     the last D words still go to d_data, not i_data.
//   6 orphan: force mem_rdata_valid=1 with empty tag pipe -> orphan_err=1 and stays 1 until rst_n=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single 16-bit main memory port between the I-cache fill FSM,
//   the D-cache fill FSM and the D-cache write-through path. A fill owns the
//   port until its requester drops req. A write is a single beat. Every read
//   issue is tagged in a LATENCY-deep pipe so that returned data reaches the
//   requester that issued it, even after the grant has moved on.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   i_req/i_addr                   I-cache fill request and word address
//   i_grant/i_data_valid/i_data    I-cache ownership, routed read data
//   d_req/d_addr                   D-cache fill request and word address
//   d_grant/d_data_valid/d_data    D-cache ownership, routed read data
//   w_req/w_addr/w_wdata/w_ack     write-through store, w_ack pulses on issue
//   mem_enable/mem_wr/mem_addr/mem_wdata   memory request port
//   mem_rdata/mem_rdata_valid      memory read return, LATENCY cycles after issue
//   orphan_err                     sticky: read data arrived with no tag at pipe head
//
// Handshake: all requests are level signals. A fill requester keeps x_req high
// for as long as it wants the port; every cycle with x_grant=1 and x_req=1 is
// one read issue. A store keeps w_req, w_addr and w_wdata stable until the
// cycle in which w_ack=1, which is the cycle the store is on the memory port.
// The arbiter state is held in state_q (enum state_e) for observation.

module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_data_valid,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_grant,
  output logic        d_data_valid,
  output logic [15:0] d_data,
  input  logic        w_req,
  input  logic [15:0] w_addr,
  input  logic [15:0] w_wdata,
  output logic        w_ack,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        orphan_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_e;

  // Requester ids carried in the tag pipe and in last_fill.
  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  state_e             state_q, state_d;
  logic               last_fill_q, last_fill_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic               orphan_q, orphan_d;

  logic rd_issue;
  logic rd_id;
  logic head_v;
  logic head_id;

  // Next-state and memory-port outputs.
  always_comb begin
    state_d     = state_q;
    last_fill_d = last_fill_q;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    w_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending store always goes first; on a fill tie the requester
        // that did not own the previous fill wins.
        if (w_req) begin
          state_d = WRITE;
        end else if (i_req && d_req) begin
          if (last_fill_q == ID_I) begin
            state_d     = FILL_D;
            last_fill_d = ID_D;
          end else begin
            state_d     = FILL_I;
            last_fill_d = ID_I;
          end
        end else if (i_req) begin
          state_d     = FILL_I;
          last_fill_d = ID_I;
        end else if (d_req) begin
          state_d     = FILL_D;
          last_fill_d = ID_D;
        end
      end
      FILL_I: begin
        mem_enable = i_req;
        mem_addr   = i_addr;
        if (!i_req) state_d = IDLE;
      end
      FILL_D: begin
        mem_enable = d_req;
        mem_addr   = d_addr;
        if (!d_req) state_d = IDLE;
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = w_addr;
        mem_wdata  = w_wdata;
        w_ack      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_issue = mem_enable & ~mem_wr;
  assign rd_id    = (state_q == FILL_D) ? ID_D : ID_I;

  // Tag pipe: stage 0 holds this cycle's issue one cycle later; the head
  // (stage LATENCY-1) lines up with the cycle mem_rdata_valid is expected.
  always_comb begin
    tag_v_d  = (tag_v_q << 1) | LATENCY'(rd_issue);
    tag_id_d = (tag_id_q << 1) | LATENCY'(rd_issue & rd_id);
  end

  assign head_v  = tag_v_q[LATENCY-1];
  assign head_id = tag_id_q[LATENCY-1];

  // Routing follows the tag, not the current grant.
  assign i_data_valid = mem_rdata_valid & head_v & (head_id == ID_I);
  assign d_data_valid = mem_rdata_valid & head_v & (head_id == ID_D);
  assign i_data       = i_data_valid ? mem_rdata : 16'h0000;
  assign d_data       = d_data_valid ? mem_rdata : 16'h0000;

  assign orphan_d   = orphan_q | (mem_rdata_valid & ~head_v);
  assign orphan_err = orphan_q;

  assign i_grant = (state_q == FILL_I);
  assign d_grant = (state_q == FILL_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_fill_q <= ID_I;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_fill_q <= last_fill_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      orphan_q    <= orphan_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by randomized requester traffic. A behavioural
//   memory returns mem_fn(addr) LATENCY cycles after each read issue. The
//   reference model tracks who owns the port and a list of expected returns
//   keyed by due cycle; every cycle all DUT outputs are compared with it.

module tb_mem_arbiter;

  localparam int LAT   = 4;
  localparam int OWN_N = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;
  localparam int OWN_W = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        i_req  = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_grant, i_data_valid;
  logic [15:0] i_data;
  logic        d_req  = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic        d_grant, d_data_valid;
  logic [15:0] d_data;
  logic        w_req   = 1'b0;
  logic [15:0] w_addr  = 16'h0000;
  logic [15:0] w_wdata = 16'h0000;
  logic        w_ack;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata       = 16'h0000;
  logic        mem_rdata_valid = 1'b0;
  logic        orphan_err;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_grant         (i_grant),
    .i_data_valid    (i_data_valid),
    .i_data          (i_data),
    .d_req           (d_req),
    .d_addr          (d_addr),
    .d_grant         (d_grant),
    .d_data_valid    (d_data_valid),
    .d_data          (d_data),
    .w_req           (w_req),
    .w_addr          (w_addr),
    .w_wdata         (w_wdata),
    .w_ack           (w_ack),
    .mem_enable      (mem_enable),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .orphan_err      (orphan_err)
  );

  // ---------------- behavioural memory ----------------
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'h3B1D) ^ 16'h5A0F;
  endfunction

  logic               issue_now   = 1'b0;
  logic [15:0]        addr_now    = 16'h0000;
  logic               force_valid = 1'b0;
  logic [LAT-1:0]     lat_v       = '0;
  logic [15:0]        lat_d [LAT];

  always @(negedge clk) begin
    issue_now = mem_enable & ~mem_wr;
    addr_now  = mem_addr;
  end

  always @(posedge clk) begin
    #2;
    for (int s = LAT - 1; s > 0; s--) begin
      lat_v[s] = lat_v[s-1];
      lat_d[s] = lat_d[s-1];
    end
    lat_v[0] = issue_now;
    lat_d[0] = mem_fn(addr_now);
    mem_rdata_valid = lat_v[LAT-1] | force_valid;
    mem_rdata       = lat_v[LAT-1] ? lat_d[LAT-1] : 16'hF00D;
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  int          owner     = OWN_N;
  int          last_fill = OWN_I;
  logic        exp_orphan = 1'b0;
  int          due_q[$];
  int          id_q[$];
  logic [15:0] exp_q[$];
  logic        issued_i = 1'b0;
  logic        issued_d = 1'b0;
  logic        wrote    = 1'b0;
  int          i_left   = 0;
  int          d_left   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: compare every output mid-cycle, then advance the model.
  task automatic step();
    logic [15:0] e_addr, e_wdata, e_idata, e_ddata;
    logic        e_en, e_wr, e_iv, e_dv, hit;
    @(negedge clk);
    e_en = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_wdata = 16'h0000;
    issued_i = 1'b0; issued_d = 1'b0; wrote = 1'b0;
    if (owner == OWN_W) begin
      e_en = 1'b1; e_wr = 1'b1; e_addr = w_addr; e_wdata = w_wdata; wrote = 1'b1;
    end else if (owner == OWN_I) begin
      e_en = i_req; e_addr = i_addr; issued_i = i_req;
    end else if (owner == OWN_D) begin
      e_en = d_req; e_addr = d_addr; issued_d = d_req;
    end
    hit = 1'b0;
    if (due_q.size() > 0) hit = (due_q[0] == cyc);
    e_iv = 1'b0; e_dv = 1'b0; e_idata = 16'h0000; e_ddata = 16'h0000;
    if (hit) begin
      if (id_q[0] == OWN_I) begin e_iv = 1'b1; e_idata = exp_q[0]; end
      else begin e_dv = 1'b1; e_ddata = exp_q[0]; end
    end
    chk1 ("i_grant",      i_grant,      owner == OWN_I);
    chk1 ("d_grant",      d_grant,      owner == OWN_D);
    chk1 ("w_ack",        w_ack,        owner == OWN_W);
    chk1 ("mem_enable",   mem_enable,   e_en);
    chk1 ("mem_wr",       mem_wr,       e_wr);
    chk16("mem_addr",     mem_addr,     e_addr);
    chk16("mem_wdata",    mem_wdata,    e_wdata);
    chk1 ("i_data_valid", i_data_valid, e_iv);
    chk16("i_data",       i_data,       e_idata);
    chk1 ("d_data_valid", d_data_valid, e_dv);
    chk16("d_data",       d_data,       e_ddata);
    chk1 ("orphan_err",   orphan_err,   exp_orphan);
    if (hit) begin
      void'(due_q.pop_front());
      void'(id_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (rst_n) begin
      if (mem_rdata_valid && !hit) exp_orphan = 1'b1;
      if (issued_i || issued_d) begin
        due_q.push_back(cyc + LAT);
        id_q.push_back(issued_i ? OWN_I : OWN_D);
        exp_q.push_back(mem_fn(e_addr));
      end
      case (owner)
        OWN_W: owner = OWN_N;
        OWN_I: if (!i_req) owner = OWN_N;
        OWN_D: if (!d_req) owner = OWN_N;
        default: begin
          if (w_req) owner = OWN_W;
          else if (i_req && d_req) owner = (last_fill == OWN_I) ? OWN_D : OWN_I;
          else if (i_req) owner = OWN_I;
          else if (d_req) owner = OWN_D;
          if (owner == OWN_I || owner == OWN_D) last_fill = owner;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle, held past any in-flight return.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("rst_i_grant",      i_grant,      1'b0);
    chk1 ("rst_d_grant",      d_grant,      1'b0);
    chk1 ("rst_w_ack",        w_ack,        1'b0);
    chk1 ("rst_mem_enable",   mem_enable,   1'b0);
    chk1 ("rst_mem_wr",       mem_wr,       1'b0);
    chk16("rst_mem_addr",     mem_addr,     16'h0000);
    chk16("rst_mem_wdata",    mem_wdata,    16'h0000);
    chk1 ("rst_i_data_valid", i_data_valid, 1'b0);
    chk16("rst_i_data",       i_data,       16'h0000);
    chk1 ("rst_d_data_valid", d_data_valid, 1'b0);
    chk16("rst_d_data",       d_data,       16'h0000);
    chk1 ("rst_orphan_err",   orphan_err,   1'b0);
    i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
    i_left = 0; d_left = 0; force_valid = 1'b0;
    owner = OWN_N; last_fill = OWN_I; exp_orphan = 1'b0;
    due_q.delete(); id_q.delete(); exp_q.delete();
    repeat (LAT + 2) step();
    rst_n = 1'b1;
  endtask

  // Random requesters that obey the request protocol.
  task automatic drive_random();
    if (issued_i) begin i_left--; i_addr = i_addr + 16'd1; end
    if (i_req && i_left == 0) i_req = 1'b0;
    else if (!i_req && $urandom_range(0, 3) == 0) begin
      i_req = 1'b1; i_left = $urandom_range(1, 6); i_addr = 16'($urandom_range(0, 65535));
    end
    if (issued_d) begin d_left--; d_addr = d_addr + 16'd1; end
    if (d_req && d_left == 0) d_req = 1'b0;
    else if (!d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1'b1; d_left = $urandom_range(1, 6); d_addr = 16'($urandom_range(0, 65535));
    end
    if (wrote) w_req = 1'b0;
    else if (!w_req && $urandom_range(0, 4) == 0) begin
      w_req = 1'b1;
      w_addr  = 16'($urandom_range(0, 65535));
      w_wdata = 16'($urandom_range(0, 65535));
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    // Reset from power-up.
    do_reset();

    // I-cache fill of 8 words at 0x1230..0x123E.
    i_req = 1'b1; i_addr = 16'h1230;
    step();
    chk1("t2_i_granted", i_grant, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      i_addr = i_addr + 16'd2;
    end
    i_req = 1'b0;
    step();
    repeat (LAT + 1) step();

    // Tie from reset: D first, one idle cycle, then I; D's in-flight words
    // return while I owns the port.
    do_reset();
    i_req = 1'b1; i_addr = 16'h2000;
    d_req = 1'b1; d_addr = 16'h3000;
    step();
    chk1("t3_d_first", d_grant, 1'b1);
    chk1("t3_i_waits", i_grant, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      d_addr = d_addr + 16'd1;
    end
    d_req = 1'b0;
    step();
    chk1("t3_idle_d", d_grant, 1'b0);
    chk1("t3_idle_i", i_grant, 1'b0);
    step();
    chk1("t3_i_next", i_grant, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      i_addr = i_addr + 16'd1;
    end
    i_req = 1'b0;
    step();
    repeat (LAT + 1) step();

    // Store raised during a D fill waits for the fill to release.
    d_req = 1'b1; d_addr = 16'h4000;
    step();
    w_req = 1'b1; w_addr = 16'hBEEF; w_wdata = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("t4_no_ack", w_ack, 1'b0);
      d_addr = d_addr + 16'd1;
    end
    d_req = 1'b0;
    step();
    chk1("t4_idle_ack", w_ack, 1'b0);
    step();
    chk1 ("t4_w_ack",  w_ack,     1'b1);
    chk1 ("t4_mem_wr", mem_wr,    1'b1);
    chk16("t4_addr",   mem_addr,  16'hBEEF);
    chk16("t4_wdata",  mem_wdata, 16'h1234);
    step();
    w_req = 1'b0;
    step();
    repeat (LAT + 1) step();

    // Orphan return with an empty tag pipe; flag is sticky until reset.
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    step();
    chk1("t6_orphan_set", orphan_err, 1'b1);
    repeat (5) step();
    chk1("t6_orphan_sticky", orphan_err, 1'b1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step();
      drive_random();
    end

    // Reset in the middle of a fill.
    for (int n = 0; n < 200; n++) begin
      if ((owner == OWN_I && i_req) || (owner == OWN_D && d_req)) break;
      step();
      drive_random();
    end
    do_reset();
    repeat (LAT + 3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
